// File: rtl/shift_reg_univ_pwr_pkg.sv
// rtl/shift_reg_univ_pwr_pkg.sv - mode and direction codes for the universal shift register
package shift_reg_univ_pwr_pkg;

  typedef enum logic [1:0] {
    MODE_PUSH  = 2'b00,
    MODE_CYCLE = 2'b01,
    MODE_LOAD  = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_reg_univ_pwr_if.sv
// rtl/shift_reg_univ_pwr_if.sv - control/data bundle between driver and shift register
interface shift_reg_univ_pwr_if
  import shift_reg_univ_pwr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SH_W  = 3,
  parameter int CNT_W = 16
);
  logic             enb;
  mode_e            modo;
  logic             dir;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] d;
  logic             s_in;
  logic             cnt_clr;
  logic [WIDTH-1:0] q;
  logic             s_out;
  logic [CNT_W-1:0] tog_cnt;
  logic             cnt_sat;

  modport master (
    output enb, modo, dir, shamt, d, s_in, cnt_clr,
    input  q, s_out, tog_cnt, cnt_sat
  );

  modport slave (
    input  enb, modo, dir, shamt, d, s_in, cnt_clr,
    output q, s_out, tog_cnt, cnt_sat
  );
endinterface

// File: rtl/shift_reg_univ_pwr_bit_popcount.sv
// rtl/shift_reg_univ_pwr_bit_popcount.sv - combinational ones-count of a WIDTH-bit vector
module bit_popcount #(
  parameter int WIDTH = 8,
  parameter int PW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] bits_i,
  output logic [PW-1:0]    count_o
);
  always_comb begin
    count_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_o = count_o + PW'(bits_i[i]);
    end
  end
endmodule

// File: rtl/shift_reg_univ_pwr.sv
// rtl/shift_reg_univ_pwr.sv - universal shift register with saturating Q toggle counter
module shift_reg_univ_pwr
  import shift_reg_univ_pwr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SH_W  = 3,
  parameter int CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  shift_reg_univ_pwr_if.slave   bus
);
  localparam int               PW   = $clog2(WIDTH + 1);
  localparam int unsigned      WU   = WIDTH;
  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             s_out_q, s_out_d;
  logic [CNT_W-1:0] tog_q, tog_d;
  logic [PW-1:0]    pc;
  logic [CNT_W:0]   sum;
  int unsigned      sh, k;

  always_comb begin
    q_d     = q_q;
    s_out_d = s_out_q;
    sh      = 32'(bus.shamt);
    k       = 0;
    case (bus.modo)
      MODE_LOAD: q_d = bus.d;
      MODE_PUSH: begin
        k = (sh > WU) ? WU : sh;
        if (k != 0) begin
          if (bus.dir == DIR_LEFT) begin
            q_d     = (q_q << k) | (bus.s_in ? ~(ONES << k) : '0);
            s_out_d = |(q_q & (ONE << (WU - k)));
          end else begin
            q_d     = (q_q >> k) | (bus.s_in ? ~(ONES >> k) : '0);
            s_out_d = |(q_q & (ONE << (k - 1)));
          end
        end
      end
      MODE_CYCLE: begin
        k = sh % WU;
        // k==0 must skip: a shift by WIDTH would zero one half of the rotate
        if (k != 0) begin
          if (bus.dir == DIR_LEFT) begin
            q_d     = (q_q << k) | (q_q >> (WU - k));
            s_out_d = |(q_q & (ONE << (WU - k)));
          end else begin
            q_d     = (q_q >> k) | (q_q << (WU - k));
            s_out_d = |(q_q & (ONE << (k - 1)));
          end
        end
      end
      default: ;
    endcase
  end

  bit_popcount #(.WIDTH(WIDTH), .PW(PW)) u_popcount (
    .bits_i  (q_q ^ q_d),
    .count_o (pc)
  );

  // One extra bit of headroom lets the carry signal saturation instead of wrapping
  always_comb begin
    sum = {1'b0, tog_q} + (CNT_W + 1)'(pc);
    if (bus.cnt_clr)
      tog_d = '0;
    else if (sum[CNT_W])
      tog_d = '1;
    else
      tog_d = sum[CNT_W-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q     <= '0;
      s_out_q <= 1'b0;
      tog_q   <= '0;
    end else if (bus.enb) begin
      q_q     <= q_d;
      s_out_q <= s_out_d;
      tog_q   <= tog_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.s_out   = s_out_q;
  assign bus.tog_cnt = tog_q;
  assign bus.cnt_sat = &tog_q;
endmodule

// File: tb/tb_shift_reg_univ_pwr.sv
// tb/tb_shift_reg_univ_pwr.sv - directed self-checking bench for shift_reg_univ_pwr
module tb_shift_reg_univ_pwr;
  import shift_reg_univ_pwr_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  shift_reg_univ_pwr_if #(.WIDTH(8), .SH_W(3), .CNT_W(16)) ifa ();
  shift_reg_univ_pwr_if #(.WIDTH(8), .SH_W(3), .CNT_W(4))  ifb ();

  shift_reg_univ_pwr #(.WIDTH(8), .SH_W(3), .CNT_W(16)) dut_a (
    .clk_i (clk), .rst_i (rst), .bus (ifa.slave)
  );
  shift_reg_univ_pwr #(.WIDTH(8), .SH_W(3), .CNT_W(4)) dut_b (
    .clk_i (clk), .rst_i (rst), .bus (ifb.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step_a(input logic en, input mode_e m, input logic dr, input logic [2:0] sa,
                        input logic [7:0] dd, input logic si, input logic clr);
    ifa.enb = en; ifa.modo = m; ifa.dir = dr; ifa.shamt = sa;
    ifa.d = dd; ifa.s_in = si; ifa.cnt_clr = clr;
    @(posedge clk); #1;
  endtask

  task automatic step_b(input mode_e m, input logic [7:0] dd, input logic clr);
    ifb.enb = 1'b1; ifb.modo = m; ifb.dir = DIR_LEFT; ifb.shamt = 3'd0;
    ifb.d = dd; ifb.s_in = 1'b0; ifb.cnt_clr = clr;
    @(posedge clk); #1;
  endtask

  task automatic chk_a(input string tag, input logic [7:0] q, input logic so, input logic [15:0] tc);
    check({tag, ".q"},   32'(ifa.q),       32'(q));
    check({tag, ".so"},  32'(ifa.s_out),   32'(so));
    check({tag, ".tog"}, 32'(ifa.tog_cnt), 32'(tc));
  endtask

  initial begin
    ifa.enb = 0; ifa.modo = MODE_HOLD; ifa.dir = 0; ifa.shamt = 0; ifa.d = 0; ifa.s_in = 0; ifa.cnt_clr = 0;
    ifb.enb = 0; ifb.modo = MODE_HOLD; ifb.dir = 0; ifb.shamt = 0; ifb.d = 0; ifb.s_in = 0; ifb.cnt_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_a("reset", 8'h00, 1'b0, 16'd0);
    check("reset.sat", 32'(ifa.cnt_sat), 32'd0);
    rst = 1'b0;

    step_a(1, MODE_LOAD,  DIR_LEFT,  3'd0, 8'hB5, 0, 0); chk_a("load_b5",   8'hB5, 1'b0, 16'd5);
    step_a(1, MODE_PUSH,  DIR_LEFT,  3'd1, 8'h00, 0, 0); chk_a("push_l1",   8'h6A, 1'b1, 16'd12);
    step_a(1, MODE_LOAD,  DIR_LEFT,  3'd0, 8'hA5, 0, 0); chk_a("load_a5",   8'hA5, 1'b1, 16'd18);
    step_a(1, MODE_CYCLE, DIR_RIGHT, 3'd3, 8'h00, 0, 0); chk_a("cyc_r3",    8'hB4, 1'b1, 16'd20);
    step_a(1, MODE_PUSH,  DIR_RIGHT, 3'd0, 8'h00, 1, 0); chk_a("push_r0",   8'hB4, 1'b1, 16'd20);
    step_a(1, MODE_PUSH,  DIR_RIGHT, 3'd7, 8'h00, 1, 0); chk_a("push_r7",   8'hFF, 1'b0, 16'd24);
    step_a(1, MODE_PUSH,  DIR_LEFT,  3'd7, 8'h00, 0, 0); chk_a("push_l7",   8'h80, 1'b1, 16'd31);
    step_a(1, MODE_CYCLE, DIR_LEFT,  3'd3, 8'h00, 0, 0); chk_a("cyc_l3",    8'h04, 1'b0, 16'd33);
    step_a(1, MODE_CYCLE, DIR_LEFT,  3'd0, 8'h00, 0, 0); chk_a("cyc_l0",    8'h04, 1'b0, 16'd33);
    for (int i = 0; i < 3; i++) begin
      step_a(0, MODE_PUSH, DIR_LEFT, 3'd2, 8'hFF, 1, 1); chk_a("enb_off",   8'h04, 1'b0, 16'd33);
    end
    step_a(1, MODE_HOLD,  DIR_LEFT,  3'd5, 8'hFF, 1, 0); chk_a("hold",      8'h04, 1'b0, 16'd33);
    step_a(1, MODE_LOAD,  DIR_LEFT,  3'd0, 8'h0F, 0, 1); chk_a("clr_load",  8'h0F, 1'b0, 16'd0);
    step_a(1, MODE_LOAD,  DIR_LEFT,  3'd0, 8'hFF, 0, 0); chk_a("load_ff",   8'hFF, 1'b0, 16'd4);
    step_a(1, MODE_PUSH,  DIR_LEFT,  3'd1, 8'h00, 0, 0); chk_a("push_fe",   8'hFE, 1'b1, 16'd5);

    #2 rst = 1'b1;
    #1 chk_a("mid_rst", 8'h00, 1'b0, 16'd0);
    @(negedge clk) rst = 1'b0;
    ifa.enb = 1'b0;

    step_b(MODE_LOAD, 8'hFF, 0);
    check("b.tog8",  32'(ifb.tog_cnt), 32'd8);
    check("b.sat0",  32'(ifb.cnt_sat), 32'd0);
    step_b(MODE_LOAD, 8'h00, 0);
    check("b.tog15", 32'(ifb.tog_cnt), 32'd15);
    check("b.sat1",  32'(ifb.cnt_sat), 32'd1);
    step_b(MODE_LOAD, 8'hFF, 1);
    check("b.clr",   32'(ifb.tog_cnt), 32'd0);
    check("b.q",     32'(ifb.q),       32'hFF);
    check("b.sat_c", 32'(ifb.cnt_sat), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
